// File: rtl/lif_spike_rate_display_pkg.sv
// lif_rate_pkg: shared widths, segment type and hex glyph table for the spike-rate display
package lif_rate_pkg;
  localparam int RATE_W = 8;
  typedef logic [6:0] seg7_t;
  typedef logic [RATE_W-1:0] rate_t;
  localparam seg7_t SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/lif_spike_rate_display_if.sv
// lif_spike_rate_display_if: spike/enable inputs and rate/display outputs of the rate display
interface lif_spike_rate_display_if;
  import lif_rate_pkg::*;
  logic  ena;
  logic  spike_in;
  rate_t rate_out;
  logic  rate_valid;
  logic  rate_sat;
  seg7_t segments;
  logic  seg_dp;
  modport master (
    output ena, spike_in,
    input  rate_out, rate_valid, rate_sat, segments, seg_dp
  );
  modport slave (
    input  ena, spike_in,
    output rate_out, rate_valid, rate_sat, segments, seg_dp
  );
endinterface

// File: rtl/lif_spike_rate_display_seg7.sv
// seg7_hex_decoder: 4-bit value to active-high 7-segment glyph (bit0=a .. bit6=g)
module seg7_hex_decoder
  import lif_rate_pkg::*;
(
  input  logic [3:0] i_nib,
  output seg7_t      o_seg
);
  assign o_seg = SEG_HEX[i_nib];
endmodule

// File: rtl/lif_spike_rate_display.sv
// lif_spike_rate_display: counts spike rising edges per window and shows the rate on a 7-seg digit
// Optional macro LIF_SPIKE_STRETCH_EN: decimal point becomes a per-spike pulse stretcher.
module lif_spike_rate_display
  import lif_rate_pkg::*;
#(
  parameter int WINDOW_CYCLES  = 1000,
  parameter int STRETCH_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  lif_spike_rate_display_if.slave bus
);
  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam logic [WW-1:0] LAST = WW'(WINDOW_CYCLES - 1);
  localparam rate_t MAXC = '1;
  if (WINDOW_CYCLES < 2 || WINDOW_CYCLES > 65535) begin : g_bad_window
    $error("WINDOW_CYCLES must be in 2..65535");
  end
  if (STRETCH_CYCLES < 1 || STRETCH_CYCLES > 255) begin : g_bad_stretch
    $error("STRETCH_CYCLES must be in 1..255");
  end
  logic          r_spike_prev;
  logic [WW-1:0] r_win_cnt;
  rate_t         r_spk_cnt;
  logic          r_sat;
  rate_t         r_rate;
  logic          r_rate_valid;
  logic          r_rate_sat;
  logic          w_evt;
  logic          w_term;
  logic          w_full;
  rate_t         w_cnt_nxt;
  logic          w_sat_nxt;
  // w_cnt_nxt/w_sat_nxt include the current event so a terminal-cycle spike lands in the closing window
  always_comb begin
    w_evt     = bus.ena & bus.spike_in & ~r_spike_prev;
    w_term    = bus.ena && (r_win_cnt == LAST);
    w_full    = r_spk_cnt == MAXC;
    w_cnt_nxt = (w_evt && !w_full) ? r_spk_cnt + 1'b1 : r_spk_cnt;
    w_sat_nxt = r_sat | (w_evt & w_full);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spike_prev <= 1'b0;
      r_win_cnt    <= '0;
      r_spk_cnt    <= '0;
      r_sat        <= 1'b0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_rate_sat   <= 1'b0;
    end else begin
      r_spike_prev <= bus.spike_in;
      r_rate_valid <= w_term;
      if (bus.ena) begin
        r_win_cnt <= w_term ? '0 : r_win_cnt + 1'b1;
        r_spk_cnt <= w_term ? '0 : w_cnt_nxt;
        r_sat     <= w_term ? 1'b0 : w_sat_nxt;
      end
      if (w_term) begin
        r_rate     <= w_cnt_nxt;
        r_rate_sat <= w_sat_nxt;
      end
    end
  end
`ifdef LIF_SPIKE_STRETCH_EN
  localparam logic [7:0] STR = 8'(STRETCH_CYCLES);
  logic [7:0] r_str;
  always_ff @(posedge clk) begin
    if (rst) r_str <= '0;
    else     r_str <= w_evt ? STR : (|r_str ? r_str - 1'b1 : r_str);
  end
  assign bus.seg_dp = |r_str;
`else
  // dp flags that the shown digit is only the low nibble of a rate above 15
  logic r_dp;
  always_ff @(posedge clk) begin
    if (rst)         r_dp <= 1'b0;
    else if (w_term) r_dp <= |w_cnt_nxt[RATE_W-1:4];
  end
  assign bus.seg_dp = r_dp;
`endif
  assign bus.rate_out   = r_rate;
  assign bus.rate_valid = r_rate_valid;
  assign bus.rate_sat   = r_rate_sat;
  seg7_hex_decoder u_dec (
    .i_nib (r_rate[3:0]),
    .o_seg (bus.segments)
  );
endmodule
